// File: rtl/uart_result_collector.sv
// -----------------------------------------------------------------------------
// uart_result_collector
//
// Purpose:
//   UART 8N1 receiver and word assembler for the matrix multiplier's serial
//   result stream. Bytes arrive low byte first. Each pair of bytes forms a
//   16-bit word. Words are stored in row-major order in an internal
//   ROW*COLUMN x 16 buffer. The buffer has a registered read port.
//
// Parameters:
//   ROW, COLUMN   result matrix size; TOTAL = ROW*COLUMN words are collected
//   CLKS_PER_BIT  clk cycles per UART bit (must be >= 4)
//
// Ports:
//   clk         clock
//   rst         asynchronous, active-high reset
//   rx_data     UART serial line, idle high
//   start       1-cycle pulse: arm the collector and clear its progress
//   rd_en       buffer read strobe
//   rd_addr     buffer read index (row-major)
//   rd_data     read data, valid one cycle after rd_en; 0 for out-of-range
//   word_valid  1-cycle pulse when a word is written to the buffer
//   word_out    last word written, held until the next word_valid
//   word_addr   index of the next word to be written
//   busy        armed and fewer than TOTAL words received
//   done        all TOTAL words received (sticky until start)
//   frame_err   sticky: stop bit sampled low while armed
//   err_count   (only with URC_ERR_COUNT_EN) saturating count of frame
//               errors while armed, cleared by start
//
// Configuration macro:
//   URC_ERR_COUNT_EN  adds the err_count port and its counter
// -----------------------------------------------------------------------------
module uart_result_collector #(
    parameter int ROW          = 10,
    parameter int COLUMN       = 10,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_data,
    input  logic        start,
    input  logic        rd_en,
    input  logic [31:0] rd_addr,
    output logic [15:0] rd_data,
    output logic        word_valid,
    output logic [15:0] word_out,
    output logic [31:0] word_addr,
    output logic        busy,
    output logic        done,
    output logic        frame_err
`ifdef URC_ERR_COUNT_EN
    ,
    output logic [7:0]  err_count
`endif
);

    localparam int TOTAL = ROW * COLUMN;
    localparam int AW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;
    localparam int CW    = $clog2(CLKS_PER_BIT);

    localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [31:0]   TOTAL_W  = 32'(TOTAL);
    localparam logic [31:0]   LAST_W   = 32'(TOTAL - 1);

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    // -------------------------------------------------------------------------
    // Input synchroniser plus one extra stage for falling-edge detection.
    // These flops reset to 1 (line idle) so that a reset does not look like a
    // start bit.
    // -------------------------------------------------------------------------
    logic rx_meta;
    logic rx_sync;
    logic rx_prev;

    // NOTE: every clocked block uses non-blocking assignments. All flops then
    // update together on the edge, whatever order the statements are in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx_data;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // -------------------------------------------------------------------------
    // Bit-level receive FSM. It runs whether or not the collector is armed.
    // It reports each finished frame with a 1-cycle strobe:
    //   byte_ok  - good stop bit; byte_data holds the byte
    //   byte_bad - stop bit was low
    // -------------------------------------------------------------------------
    rx_state_t   state;
    logic [CW-1:0] timer;
    logic [2:0]  bit_idx;
    logic [7:0]  shift;
    logic        byte_ok;
    logic        byte_bad;
    logic [7:0]  byte_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RX_IDLE;
            timer     <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            byte_ok   <= 1'b0;
            byte_bad  <= 1'b0;
            byte_data <= '0;
        end else begin
            byte_ok  <= 1'b0;
            byte_bad <= 1'b0;
            case (state)
                RX_IDLE: begin
                    if (rx_prev && !rx_sync) begin
                        state <= RX_START;
                        timer <= '0;
                    end
                end
                RX_START: begin
                    // Re-check the line at mid start bit. If it is high again,
                    // the low level was only a glitch.
                    if (timer == HALF_END) begin
                        timer   <= '0;
                        bit_idx <= '0;
                        state   <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (timer == BIT_END) begin
                        timer <= '0;
                        shift <= {rx_sync, shift[7:1]};  // LSB arrives first
                        if (bit_idx == 3'd7) begin
                            state <= RX_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (timer == BIT_END) begin
                        timer <= '0;
                        state <= RX_IDLE;
                        if (rx_sync) begin
                            byte_ok   <= 1'b1;
                            byte_data <= shift;
                        end else begin
                            byte_bad <= 1'b1;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Word assembly and control. start has priority over everything else. A
    // word that completes in the same cycle as start is dropped.
    // -------------------------------------------------------------------------
    logic       phase_hi;  // 0: next byte is the LOW byte, 1: HIGH byte
    logic [7:0] lo_byte;
    logic       wr_en;

    assign wr_en = byte_ok && busy && phase_hi && !start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_addr  <= '0;
            phase_hi   <= 1'b0;
            lo_byte    <= '0;
            word_valid <= 1'b0;
            word_out   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            frame_err  <= 1'b0;
`ifdef URC_ERR_COUNT_EN
            err_count  <= '0;
`endif
        end else begin
            word_valid <= 1'b0;
            if (start) begin
                word_addr <= '0;
                phase_hi  <= 1'b0;
                done      <= 1'b0;
                frame_err <= 1'b0;
                busy      <= 1'b1;
`ifdef URC_ERR_COUNT_EN
                err_count <= '0;
`endif
            end else if (byte_bad) begin
                // A corrupted frame restarts byte pairing. The next good byte
                // is taken as a LOW byte.
                phase_hi <= 1'b0;
                if (busy) begin
                    frame_err <= 1'b1;
`ifdef URC_ERR_COUNT_EN
                    if (err_count != 8'hFF) begin
                        err_count <= err_count + 1'b1;
                    end
`endif
                end
            end else if (byte_ok && busy) begin
                if (!phase_hi) begin
                    lo_byte  <= byte_data;
                    phase_hi <= 1'b1;
                end else begin
                    phase_hi   <= 1'b0;
                    word_valid <= 1'b1;
                    word_out   <= {byte_data, lo_byte};
                    word_addr  <= word_addr + 1'b1;
                    if (word_addr == LAST_W) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                    end
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Result buffer with a registered read port. A read and a write to the same
    // address in one cycle return the old data.
    // -------------------------------------------------------------------------
    logic [15:0] mem [TOTAL];

    // NOTE: the buffer array has no reset. Its contents are undefined until it
    // is written, which lets it map onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[word_addr[AW-1:0]] <= {byte_data, lo_byte};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= (rd_addr < TOTAL_W) ? mem[rd_addr[AW-1:0]] : 16'h0000;
        end
    end

endmodule

// File: tb/tb_uart_result_collector.sv
// -----------------------------------------------------------------------------
// tb_uart_result_collector
//
// Directed bench for uart_result_collector with ROW=COLUMN=2, CLKS_PER_BIT=8.
// Buffer contents are checked through a table of {rd_addr, expected rd_data}
// records. Hand-written sequences cover the multi-cycle corner cases: glitch,
// bad stop bit, bytes after done, restart, and reset mid-frame. Define
// URC_ERR_COUNT_EN to also exercise the error counter.
// -----------------------------------------------------------------------------
module tb_uart_result_collector;

    localparam int CPB = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_data;
    logic        start;
    logic        rd_en;
    logic [31:0] rd_addr;
    logic [15:0] rd_data;
    logic        word_valid;
    logic [15:0] word_out;
    logic [31:0] word_addr;
    logic        busy;
    logic        done;
    logic        frame_err;
`ifdef URC_ERR_COUNT_EN
    logic [7:0]  err_count;
`endif

    uart_result_collector #(
        .ROW          (2),
        .COLUMN       (2),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .start      (start),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .word_valid (word_valid),
        .word_out   (word_out),
        .word_addr  (word_addr),
        .busy       (busy),
        .done       (done),
        .frame_err  (frame_err)
`ifdef URC_ERR_COUNT_EN
        ,
        .err_count  (err_count)
`endif
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int wv_count = 0;

    always @(negedge clk) begin
        if (word_valid === 1'b1) wv_count++;
    end

    typedef struct {
        logic [31:0] addr;
        logic [15:0] exp;
    } rd_vec_t;

    rd_vec_t     vecs [6];
    logic [7:0]  tx_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    // All stimulus tasks start and end at 1 time unit after a rising edge.
    task automatic drive_bit(input logic v);
        rx_data = v;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_bit);
        drive_bit(1'b1);  // idle gap
    endtask

    task automatic send_queue();
        foreach (tx_q[i]) send_byte(tx_q[i], 1'b1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, output logic [15:0] d);
        rd_en   = 1'b1;
        rd_addr = a;
        @(posedge clk);
        #1;
        rd_en = 1'b0;
        d = rd_data;
    endtask

    task automatic run_table(input string tag);
        logic [15:0] d;
        foreach (vecs[i]) begin
            do_read(vecs[i].addr, d);
            check($sformatf("%s rd[%0d]", tag, vecs[i].addr), 32'(d), 32'(vecs[i].exp));
        end
    endtask

    initial begin
        logic [15:0] d;
        int wv_base;

        rst = 1'b1; rx_data = 1'b1; start = 1'b0; rd_en = 1'b0; rd_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy",       32'(busy),       32'd0);
        check("reset done",       32'(done),       32'd0);
        check("reset frame_err",  32'(frame_err),  32'd0);
        check("reset word_valid", 32'(word_valid), 32'd0);
        check("reset word_addr",  word_addr,       32'd0);
        check("reset rd_data",    32'(rd_data),    32'd0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // ---- 1: basic stream ------------------------------------------------
        pulse_start();
        check("t1 busy after start", 32'(busy), 32'd1);
        tx_q = '{8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A, 8'hF0, 8'hDE};
        send_queue();
        check("t1 word_valid count", 32'(wv_count), 32'd4);
        check("t1 word_out",  32'(word_out), 32'h0000DEF0);
        check("t1 word_addr", word_addr, 32'd4);
        check("t1 done",      32'(done), 32'd1);
        check("t1 busy",      32'(busy), 32'd0);
        vecs = '{'{32'd2, 16'h9ABC}, '{32'd0, 16'h1234}, '{32'd1, 16'h5678},
                 '{32'd3, 16'hDEF0}, '{32'd4, 16'h0000}, '{32'd100, 16'h0000}};
        run_table("t1");
        do_read(32'd2, d);
        rd_addr = 32'd0;  // without rd_en the output must hold
        repeat (3) @(posedge clk);
        #1;
        check("t1 rd_data hold", 32'(rd_data), 32'h00009ABC);

        // ---- 2: short glitch ------------------------------------------------
        pulse_start();
        wv_base = wv_count;
        rx_data = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rx_data = 1'b1;
        repeat (12 * CPB) @(posedge clk);
        #1;
        check("t2 no word",   32'(wv_count - wv_base), 32'd0);
        check("t2 frame_err", 32'(frame_err), 32'd0);
        check("t2 word_addr", word_addr, 32'd0);

        // ---- 3: bad stop bit, then a good word ------------------------------
        send_byte(8'h34, 1'b0);
        check("t3 frame_err", 32'(frame_err), 32'd1);
        check("t3 no word",   32'(wv_count - wv_base), 32'd0);
        tx_q = '{8'h78, 8'h56};
        send_queue();
        check("t3 word_out",  32'(word_out), 32'h00005678);
        check("t3 word_addr", word_addr, 32'd1);
        do_read(32'd0, d);
        check("t3 rd[0]", 32'(d), 32'h00005678);

        // ---- 4: bytes after done are ignored; restart overwrites ------------
        tx_q = '{8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00};
        send_queue();
        check("t4 done", 32'(done), 32'd1);
        wv_base = wv_count;
        tx_q = '{8'h11, 8'h22};
        send_queue();
        check("t4 word_addr stays", word_addr, 32'd4);
        check("t4 no word after done", 32'(wv_count - wv_base), 32'd0);
        do_read(32'd0, d);
        check("t4 rd[0] unchanged", 32'(d), 32'h00005678);
        do_read(32'd3, d);
        check("t4 rd[3] unchanged", 32'(d), 32'h00000003);
        pulse_start();
        check("t4 frame_err cleared", 32'(frame_err), 32'd0);
        check("t4 done cleared",      32'(done), 32'd0);
        check("t4 word_addr cleared", word_addr, 32'd0);
        tx_q = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h0D, 8'hF0, 8'hFE, 8'hCA};
        send_queue();
        check("t4 done again", 32'(done), 32'd1);
        vecs = '{'{32'd0, 16'hBEEF}, '{32'd1, 16'hDEAD}, '{32'd2, 16'hF00D},
                 '{32'd3, 16'hCAFE}, '{32'd5, 16'h0000}, '{32'hFFFF_FFFF, 16'h0000}};
        run_table("t4");

        // ---- 5: reset in the middle of the 3rd byte -------------------------
        pulse_start();
        send_byte(8'h34, 1'b1);
        send_byte(8'h12, 1'b1);
        check("t5 word_addr before rst", word_addr, 32'd1);
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b1);
        rx_data = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("t5 rst busy",       32'(busy),       32'd0);
        check("t5 rst done",       32'(done),       32'd0);
        check("t5 rst word_addr",  word_addr,       32'd0);
        check("t5 rst word_out",   32'(word_out),   32'd0);
        check("t5 rst word_valid", 32'(word_valid), 32'd0);
        check("t5 rst rd_data",    32'(rd_data),    32'd0);
        check("t5 rst frame_err",  32'(frame_err),  32'd0);
        rx_data = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2 * CPB) @(posedge clk);
        #1;
        pulse_start();
        tx_q = '{8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A, 8'hF0, 8'hDE};
        send_queue();
        check("t5 done", 32'(done), 32'd1);
        check("t5 frame_err", 32'(frame_err), 32'd0);
        vecs = '{'{32'd0, 16'h1234}, '{32'd1, 16'h5678}, '{32'd2, 16'h9ABC},
                 '{32'd3, 16'hDEF0}, '{32'd4, 16'h0000}, '{32'd2, 16'h9ABC}};
        run_table("t5");

`ifdef URC_ERR_COUNT_EN
        // ---- 6: error counter saturation ------------------------------------
        pulse_start();
        check("t6 err_count cleared", 32'(err_count), 32'd0);
        send_byte(8'h55, 1'b0);
        check("t6 err_count one", 32'(err_count), 32'd1);
        for (int i = 1; i < 300; i++) send_byte(8'h55, 1'b0);
        check("t6 err_count saturated", 32'(err_count), 32'd255);
        check("t6 still busy", 32'(busy), 32'd1);
        pulse_start();
        check("t6 err_count after start", 32'(err_count), 32'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
